// File: rtl/parking_pkg.sv
// ============================================================================
// Module   : parking_pkg
// Purpose  : Shared types, constants and exit-code helper for the parking lot.
// Revision : 1.0
// ============================================================================
`default_nettype none

package parking_pkg;

    localparam int NUM_SLOTS = 7;
    localparam logic [7:0] DEFAULT_CODE_BASE = 8'd47;

    typedef logic [2:0] slot_idx_t;
    typedef logic [7:0] code_t;

    function automatic code_t code_of(input slot_idx_t slot,
                                      input code_t base = DEFAULT_CODE_BASE);
        return base + code_t'(slot);
    endfunction

endpackage

`default_nettype wire

// File: rtl/slot_allocator.sv
// ============================================================================
// Module   : slot_allocator
// Purpose  : Combinational priority encoder picking the highest free slot.
// Revision : 1.0
// ============================================================================
`default_nettype none

module slot_allocator
    import parking_pkg::*;
(
    input  logic [7:1]  i_occupancy,
    output logic        o_found,
    output slot_idx_t   o_slot_idx
);

    // Ascending scan: the last free slot seen is the highest-numbered one.
    always_comb begin
        o_found    = 1'b0;
        o_slot_idx = '0;
        for (int i = 1; i <= NUM_SLOTS; i++) begin
            if (!i_occupancy[i]) begin
                o_found    = 1'b1;
                o_slot_idx = slot_idx_t'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/parking_system.sv
// ============================================================================
// Module   : parking_system
// Purpose  : Seven-slot parking controller: allocation, coded exit, panel data.
// Revision : 1.0
// ============================================================================
`default_nettype none

module parking_system
    import parking_pkg::*;
#(
    parameter code_t CODE_BASE = DEFAULT_CODE_BASE
)
(
    input  logic        clock,
    input  logic        g1_reset,
    output logic [7:1]  register,
    input  logic        car_exit,
    input  logic [2:0]  exit_from,
    input  logic [7:0]  exit_code,
    input  logic        car_arrival,
    output logic [2:0]  available_slots,
    output logic        can_park,
    output logic [7:0]  l0,
    output logic [7:0]  l1,
    output logic [7:0]  l2,
    output logic [7:0]  l3,
    output logic [7:0]  l4,
    output logic [7:0]  l5,
    output logic [7:0]  l6,
    output logic [7:0]  l7
);

    // Initialisers give reset-equivalent power-up state.
    logic [7:1] r_occ     = '0;
    code_t      r_last    = '0;
    code_t      w_code [1:7];

    logic       w_found;
    slot_idx_t  w_slot;
    logic [7:1] w_arr_hot;
    logic [7:1] w_exit_dec;
    logic [7:1] w_exit_hot;
    logic       w_exit_ok;
    logic [2:0] w_count;

    slot_allocator u_alloc (
        .i_occupancy (r_occ),
        .o_found     (w_found),
        .o_slot_idx  (w_slot)
    );

    // exit_from==0 decodes to no slot, so it can never be accepted.
    always_comb begin
        w_arr_hot  = '0;
        w_exit_dec = '0;
        for (int i = 1; i <= NUM_SLOTS; i++) begin
            w_arr_hot[i]  = car_arrival && w_found && (w_slot == slot_idx_t'(i));
            w_exit_dec[i] = (exit_from == slot_idx_t'(i));
        end
        w_exit_ok  = car_exit && (|(r_occ & w_exit_dec))
                     && (exit_code == code_of(exit_from, CODE_BASE));
        w_exit_hot = w_exit_ok ? w_exit_dec : '0;
    end

    always_ff @(posedge clock) begin
        if (g1_reset) begin
            r_occ  <= '0;
            r_last <= '0;
        end else begin
            r_occ <= (r_occ | w_arr_hot) & ~w_exit_hot;
            if (car_arrival && w_found)
                r_last <= code_of(w_slot, CODE_BASE);
        end
    end

    for (genvar g = 1; g <= NUM_SLOTS; g++) begin : g_slot
        code_t r_code = '0;

        always_ff @(posedge clock) begin
            if (g1_reset)
                r_code <= '0;
            else if (w_arr_hot[g])
                r_code <= code_of(slot_idx_t'(g), CODE_BASE);
            else if (w_exit_hot[g])
                r_code <= '0;
        end

        assign w_code[g] = r_code;
    end

    always_comb begin
        w_count = '0;
        for (int i = 1; i <= NUM_SLOTS; i++)
            w_count = w_count + 3'(r_occ[i]);
    end

    assign register        = r_occ;
    assign available_slots = 3'(NUM_SLOTS) - w_count;
    assign can_park        = (available_slots != 3'd0);
    assign l0              = r_last;
    assign l1              = w_code[1];
    assign l2              = w_code[2];
    assign l3              = w_code[3];
    assign l4              = w_code[4];
    assign l5              = w_code[5];
    assign l6              = w_code[6];
    assign l7              = w_code[7];

endmodule

`default_nettype wire

// File: tb/tb_parking_system.sv
// ============================================================================
// Module   : tb_parking_system
// Purpose  : Directed self-checking bench for parking_system.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_parking_system;

    logic       clock = 1'b0;
    logic       g1_reset = 1'b0;
    logic [7:1] register;
    logic       car_exit = 1'b0;
    logic [2:0] exit_from = 3'd0;
    logic [7:0] exit_code = 8'd0;
    logic       car_arrival = 1'b0;
    logic [2:0] available_slots;
    logic       can_park;
    logic [7:0] l0, l1, l2, l3, l4, l5, l6, l7;

    int checks = 0;
    int errors = 0;

    parking_system dut (
        .clock           (clock),
        .g1_reset        (g1_reset),
        .register        (register),
        .car_exit        (car_exit),
        .exit_from       (exit_from),
        .exit_code       (exit_code),
        .car_arrival     (car_arrival),
        .available_slots (available_slots),
        .can_park        (can_park),
        .l0              (l0),
        .l1              (l1),
        .l2              (l2),
        .l3              (l3),
        .l4              (l4),
        .l5              (l5),
        .l6              (l6),
        .l7              (l7)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("%s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample 1 time unit after the edge.
    task automatic cyc(input logic rst, input logic arr, input logic ex,
                       input logic [2:0] from, input logic [7:0] code);
        g1_reset    = rst;
        car_arrival = arr;
        car_exit    = ex;
        exit_from   = from;
        exit_code   = code;
        @(posedge clock);
        #1;
        g1_reset    = 1'b0;
        car_arrival = 1'b0;
        car_exit    = 1'b0;
        exit_from   = 3'd0;
        exit_code   = 8'd0;
    endtask

    initial begin
        #1;
        // Power-up, no reset pulse yet
        cyc(0, 0, 0, 0, 0);
        check("pwrup_reg",   register, 7'h00);
        check("pwrup_avail", available_slots, 3'd7);
        check("pwrup_l0",    l0, 8'd0);

        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        check("rst_reg",   register, 7'h00);
        check("rst_avail", available_slots, 3'd7);
        check("rst_park",  can_park, 1'b1);
        check("rst_l0",    l0, 8'd0);
        check("rst_l7",    l7, 8'd0);

        cyc(0, 1, 0, 0, 0);
        check("arr1_reg",   register, 7'b1000000);
        check("arr1_l7",    l7, 8'd54);
        check("arr1_l0",    l0, 8'd54);
        check("arr1_avail", available_slots, 3'd6);

        cyc(0, 0, 1, 3'd7, 8'd54);
        check("ex7_reg",   register, 7'h00);
        check("ex7_l7",    l7, 8'd0);
        check("ex7_avail", available_slots, 3'd7);
        check("ex7_l0",    l0, 8'd54);

        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        check("arr2_reg", register, 7'b1100000);
        check("arr2_l6",  l6, 8'd53);
        check("arr2_l0",  l0, 8'd53);

        cyc(0, 0, 1, 3'd6, 8'd53);
        check("ex6_reg",   register, 7'b1000000);
        check("ex6_l6",    l6, 8'd0);
        check("ex6_avail", available_slots, 3'd6);

        cyc(0, 0, 1, 3'd7, 8'd53);
        check("badcode_reg", register, 7'b1000000);
        check("badcode_l7",  l7, 8'd54);
        cyc(0, 0, 1, 3'd3, 8'd50);
        check("freeslot_reg", register, 7'b1000000);
        cyc(0, 0, 1, 3'd0, 8'd47);
        check("slot0_reg", register, 7'b1000000);

        for (int i = 0; i < 7; i++) cyc(0, 1, 0, 0, 0);
        check("full_reg",   register, 7'h7F);
        check("full_avail", available_slots, 3'd0);
        check("full_park",  can_park, 1'b0);
        check("full_l1",    l1, 8'd48);
        check("full_l0",    l0, 8'd48);

        cyc(0, 1, 0, 0, 0);
        check("over_reg", register, 7'h7F);
        check("over_l0",  l0, 8'd48);

        // Arrival sees pre-edge full lot; only the exit takes effect
        cyc(0, 1, 1, 3'd4, 8'd51);
        check("simul_reg",   register, 7'h77);
        check("simul_avail", available_slots, 3'd1);
        check("simul_park",  can_park, 1'b1);
        check("simul_l4",    l4, 8'd0);
        check("simul_l0",    l0, 8'd48);

        cyc(0, 1, 0, 0, 0);
        check("refill_reg", register, 7'h7F);
        check("refill_l4",  l4, 8'd51);
        check("refill_l0",  l0, 8'd51);

        cyc(0, 0, 1, 3'd1, 8'd48);
        check("ex1_reg", register, 7'h7E);
        check("ex1_l1",  l1, 8'd0);

        cyc(1, 1, 0, 0, 0);
        check("rst2_reg",   register, 7'h00);
        check("rst2_avail", available_slots, 3'd7);
        check("rst2_l0",    l0, 8'd0);
        check("rst2_l5",    l5, 8'd0);
        check("rst2_l7",    l7, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
